// File: rtl/regbank_write_arbiter_pkg.sv
// Shared widths, FSM state type and enable decode for the register-bank write arbiter.
// No logic of its own; imported by the interface, arbiter core and top.
package regbank_pkg;
   localparam int NUM_REGS   = 16;
   localparam int IDX_W      = 4;
   localparam int DEF_DATA_W = 32;
   localparam int REQ_ID_W   = 3;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   function automatic logic [NUM_REGS-1:0] onehot16(input logic [IDX_W-1:0] idx);
      return NUM_REGS'(1) << idx;
   endfunction
endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Requester handshake bundle plus the registered bank write port.
// slave = arbiter side, master = requester/bank side.
interface regbank_write_arbiter_if
   import regbank_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEF_DATA_W
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [IDX_W*NUM_REQ-1:0]  req_idx;
   logic [DATA_W*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REGS-1:0]       wr_enable;
   logic [DATA_W-1:0]         wr_data;
   logic [REQ_ID_W-1:0]       grant_id;

   modport slave (
      input  req_valid, req_idx, req_data, req_lock,
      output req_ready, wr_enable, wr_data, grant_id
   );

   modport master (
      output req_valid, req_idx, req_data, req_lock,
      input  req_ready, wr_enable, wr_data, grant_id
   );
endinterface

// File: rtl/regbank_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible request at or after ptr, wrapping.
// Zero latency; gnt is all-zero when nothing is eligible.
module rr_arbiter
   import regbank_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [REQ_ID_W-1:0] ptr,
   input  logic [NUM_REQ-1:0]  mask,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [REQ_ID_W-1:0] gnt_idx
);
   logic [NUM_REQ-1:0] eligible;
   logic               found;
   int                 cand;

   always_comb begin
      eligible = req & mask;
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(ptr) + k) % NUM_REQ;
         if (!found && eligible[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = REQ_ID_W'(cand);
         end
      end
   end
endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter with bounded bus lock for the register bank write port; 1-cycle accept-to-write.
// Backpressure: only the single winner sees ready; losers simply hold valid.
module regbank_write_arbiter
   import regbank_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_LOCK = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   regbank_write_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   state_t               state_q, state_d;
   logic [REQ_ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [REQ_ID_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
   logic [NUM_REGS-1:0]  wr_enable_q, wr_enable_d;
   logic [DATA_W-1:0]    wr_data_q, wr_data_d;
   logic [REQ_ID_W-1:0]  grant_id_q, grant_id_d;

   logic [NUM_REQ-1:0]   arb_mask;
   logic [NUM_REQ-1:0]   arb_gnt;
   logic [REQ_ID_W-1:0]  arb_idx;
   logic                 accept;
   logic                 win_lock;
   logic [IDX_W-1:0]     win_reg;
   logic [DATA_W-1:0]    win_data;

   function automatic logic [REQ_ID_W-1:0] wrap_inc(input logic [REQ_ID_W-1:0] i);
      return (i == REQ_ID_W'(NUM_REQ - 1)) ? '0 : i + REQ_ID_W'(1);
   endfunction

   // While locked, the owner is the only eligible requester.
   always_comb begin
      arb_mask = '1;
      if (state_q == ST_LOCKED) begin
         arb_mask          = '0;
         arb_mask[owner_q] = 1'b1;
      end
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req     (bus.req_valid),
      .ptr     (rr_ptr_q),
      .mask    (arb_mask),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   assign accept   = (|arb_gnt) && !reset;
   assign win_lock = bus.req_lock[arb_idx];
   assign win_reg  = bus.req_idx[int'(arb_idx)*IDX_W +: IDX_W];
   assign win_data = bus.req_data[int'(arb_idx)*DATA_W +: DATA_W];

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      lock_cnt_d  = lock_cnt_q;
      wr_enable_d = '0;
      wr_data_d   = wr_data_q;
      grant_id_d  = grant_id_q;

      if (accept) begin
         wr_enable_d = onehot16(win_reg);
         wr_data_d   = win_data;
         grant_id_d  = arb_idx;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               // A limit of one beat means a lock can never outlive its first beat.
               if (win_lock && MAX_LOCK > 1) begin
                  state_d    = ST_LOCKED;
                  owner_d    = arb_idx;
                  lock_cnt_d = CNT_W'(1);
               end else begin
                  rr_ptr_d = wrap_inc(arb_idx);
               end
            end
         end
         ST_LOCKED: begin
            if (accept) begin
               if (!win_lock || (int'(lock_cnt_q) + 1 >= MAX_LOCK)) begin
                  state_d    = ST_IDLE;
                  rr_ptr_d   = wrap_inc(owner_q);
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         lock_cnt_q  <= '0;
         wr_enable_q <= '0;
         wr_data_q   <= '0;
         grant_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         lock_cnt_q  <= lock_cnt_d;
         wr_enable_q <= wr_enable_d;
         wr_data_q   <= wr_data_d;
         grant_id_q  <= grant_id_d;
      end
   end

   assign bus.req_ready = reset ? '0 : arb_gnt;
   assign bus.wr_enable = wr_enable_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.grant_id  = grant_id_q;
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Bench: directed scenarios plus random traffic, all checked each cycle against a behavioural model.
module tb_regbank_write_arbiter;
   localparam int N    = 4;
   localparam int DW   = 32;
   localparam int MAXL = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   regbank_write_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

   regbank_write_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what the bus owner/pointer must be according to the arbitration rules.
   bit          m_init = 1'b0;
   bit          m_locked;
   int          m_owner, m_beats, m_ptr;
   logic [15:0] m_en;
   logic [31:0] m_dat;
   logic [2:0]  m_gid;

   int g_log[$];
   int en_log[$];
   int d_log[$];

   always @(negedge clk) begin
      int win;
      int j;
      logic [3:0] exp_rdy;
      win = -1;
      if (!reset) begin
         if (m_locked) begin
            if (bus.req_valid[m_owner]) win = m_owner;
         end else begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (win < 0 && bus.req_valid[j]) win = j;
            end
         end
      end
      if (m_init) begin
         exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0;
         check("req_ready", bus.req_ready, exp_rdy);
         check("wr_enable", bus.wr_enable, m_en);
         check("wr_data", bus.wr_data, m_dat);
         check("grant_id", bus.grant_id, m_gid);
         check("onehot0_ready", $onehot0(bus.req_ready), 1);
         check("onehot0_enable", $onehot0(bus.wr_enable), 1);
         if (!reset)
            for (int i = 0; i < N; i++)
               if (bus.req_valid[i] && bus.req_ready[i]) g_log.push_back(i);
         if (bus.wr_enable != 0) begin
            en_log.push_back(int'(bus.wr_enable));
            d_log.push_back(int'(bus.wr_data));
         end
      end
      if (reset) begin
         m_init   = 1'b1;
         m_locked = 1'b0;
         m_owner  = 0;
         m_beats  = 0;
         m_ptr    = 0;
         m_en     = '0;
         m_dat    = '0;
         m_gid    = '0;
      end else if (win >= 0) begin
         m_en  = 16'(1) << bus.req_idx[win*4 +: 4];
         m_dat = bus.req_data[win*DW +: DW];
         m_gid = 3'(win);
         if (!m_locked) begin
            if (bus.req_lock[win] && MAXL > 1) begin
               m_locked = 1'b1;
               m_owner  = win;
               m_beats  = 1;
            end else begin
               m_ptr = (win + 1) % N;
            end
         end else begin
            m_beats++;
            if (!bus.req_lock[win] || m_beats >= MAXL) begin
               m_locked = 1'b0;
               m_ptr    = (m_owner + 1) % N;
            end
         end
      end else begin
         m_en = '0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] v, input logic [3:0] lk);
      bus.req_valid = v;
      bus.req_lock  = lk;
   endtask

   task automatic default_payload();
      for (int i = 0; i < N; i++) begin
         bus.req_idx[i*4 +: 4]   = 4'(i + 1);
         bus.req_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
      end
   endtask

   task automatic clear_logs();
      g_log.delete();
      en_log.delete();
      d_log.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_in(4'b0, 4'b0);
      cyc(2);
      reset = 1'b0;
   endtask

   task automatic check_log(input string name, input int got[$], input int want[$]);
      check({name, "_len"}, got.size() >= want.size(), 1);
      for (int i = 0; i < want.size(); i++)
         if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], want[i]);
   endtask

   initial begin
      int eq[$];
      default_payload();
      set_in(4'b1111, 4'b0000);
      reset = 1'b1;
      cyc(3);
      check("rst_ready", bus.req_ready, 0);
      check("rst_wr_enable", bus.wr_enable, 0);
      check("rst_grant_id", bus.grant_id, 0);

      // Fair rotation with everyone requesting.
      reset = 1'b0;
      clear_logs();
      cyc(8);
      eq = '{0, 1, 2, 3, 0, 1, 2, 3};
      check_log("rr_grants", g_log, eq);
      eq = '{32'h0002, 32'h0004, 32'h0008, 32'h0010};
      check_log("rr_enable", en_log, eq);

      // Lock held by req2 for four beats, then release to req0.
      do_reset();
      clear_logs();
      set_in(4'b0100, 4'b0100); cyc(1);
      set_in(4'b0111, 4'b0100); cyc(1);
      check("lock_ready", bus.req_ready, 4'b0100);
      cyc(1);
      set_in(4'b0111, 4'b0000); cyc(1);
      set_in(4'b0011, 4'b0000); cyc(1);
      set_in(4'b0000, 4'b0000); cyc(1);
      eq = '{2, 2, 2, 2, 0};
      check_log("lock_grants", g_log, eq);

      // Lock timeout after MAXL beats, then fair rotation before req1 again.
      do_reset();
      clear_logs();
      set_in(4'b0010, 4'b0010); cyc(1);
      set_in(4'b1111, 4'b0010); cyc(11);
      eq = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 3, 0, 1};
      check_log("timeout_grants", g_log, eq);

      // Same destination from req3 then req0, starting from rr_ptr=3.
      do_reset();
      clear_logs();
      set_in(4'b0100, 4'b0000); cyc(1);
      bus.req_idx[0 +: 4]      = 4'd5;
      bus.req_idx[12 +: 4]     = 4'd5;
      bus.req_data[0 +: DW]    = 32'hAAAA_AAAA;
      bus.req_data[3*DW +: DW] = 32'h5555_5555;
      set_in(4'b1001, 4'b0000); cyc(2);
      set_in(4'b0000, 4'b0000); cyc(2);
      eq = '{2, 3, 0};
      check_log("coll_grants", g_log, eq);
      eq = '{32'h0008, 32'h0020, 32'h0020};
      check_log("coll_enable", en_log, eq);
      eq = '{32'h1000_0002, 32'h5555_5555, 32'hAAAA_AAAA};
      check_log("coll_data", d_log, eq);

      // Reset in the middle of a lock with a beat on the write port.
      default_payload();
      do_reset();
      set_in(4'b0001, 4'b0001); cyc(3);
      check("midlock_pending", bus.wr_enable, 16'h0002);
      reset = 1'b1; cyc(1);
      check("midlock_rst_en", bus.wr_enable, 0);
      reset = 1'b0;
      set_in(4'b1111, 4'b0000);
      clear_logs();
      cyc(2);
      eq = '{0, 1};
      check_log("after_rst_grants", g_log, eq);

      // Random traffic, checked cycle by cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         reset         = ($urandom_range(0, 299) == 0);
         bus.req_valid = 4'($urandom);
         bus.req_lock  = 4'($urandom);
         bus.req_idx   = 16'($urandom);
         bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
         cyc(1);
      end
      reset = 1'b0;
      set_in(4'b0000, 4'b0000);
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
